// File: rtl/sram_responder_if.sv
// Master-side bus between the arbiter and the SRAM responder.
interface sram_responder_if;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_dat;
   logic [DATA_W-1:0] o_dat;
   logic              i_we;
   logic              i_cs;
   logic              o_ack;

   modport master (output i_addr, output i_dat, output i_we, output i_cs,
                   input  o_dat,  input  o_ack);
   modport slave  (input  i_addr, input  i_dat, input  i_we, input  i_cs,
                   output o_dat,  output o_ack);
endinterface

// File: rtl/sram_responder.sv
// Bus responder sequencing each request into a setup/strobe/hold cycle on an
// asynchronous 8-bit SRAM, completed by a level acknowledge.
module sram_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   sram_responder_if.slave bus,
   output logic [15:0] o_sram_addr,
   output logic [7:0]  o_sram_dq,
   input  logic [7:0]  i_sram_dq,
   output logic        o_sram_dq_oe,
   output logic        o_sram_ce_n,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_HOLD,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0] sram_dq_q, sram_dq_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              we_eff;
   logic              cyc_active;

   // State and pin registers; reset parks every strobe inactive at once.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         rd_dat_q    <= '0;
         sram_addr_q <= '0;
         sram_dq_q   <= '0;
         dq_oe_q     <= 1'b0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         rd_dat_q    <= rd_dat_d;
         sram_addr_q <= sram_addr_d;
         sram_dq_q   <= sram_dq_d;
         dq_oe_q     <= dq_oe_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
      end
   end

   // Next state, request latching, and pin values decoded from the next state
   // so the registered pins line up with the phase they belong to.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      rd_dat_d    = rd_dat_q;
      sram_addr_d = sram_addr_q;
      sram_dq_d   = sram_dq_q;
      we_eff      = we_q;

      case (state_q)
         S_IDLE: begin
            if (bus.i_cs) begin
               state_d     = S_SETUP;
               we_d        = bus.i_we;
               we_eff      = bus.i_we;
               sram_addr_d = bus.i_addr;
               cnt_d       = CNT_LOAD;
               if (bus.i_we) begin
                  sram_dq_d = bus.i_dat;
               end
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = S_HOLD;
               if (!we_q) begin
                  rd_dat_d = i_sram_dq;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HOLD: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!bus.i_cs) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cyc_active = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_HOLD);
      ce_n_d     = !cyc_active;
      oe_n_d     = !(!we_eff && ((state_d == S_SETUP) || (state_d == S_ACCESS)));
      we_n_d     = !(we_eff && (state_d == S_ACCESS));
      dq_oe_d    = we_eff && cyc_active;
   end

   // Ack is gated by the live request so a dropped cs never sees a stale ack.
   assign bus.o_ack    = (state_q == S_DONE) && bus.i_cs;
   assign bus.o_dat    = rd_dat_q;
   assign o_sram_addr  = sram_addr_q;
   assign o_sram_dq    = sram_dq_q;
   assign o_sram_dq_oe = dq_oe_q;
   assign o_sram_ce_n  = ce_n_q;
   assign o_sram_oe_n  = oe_n_q;
   assign o_sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder at WAIT_CYCLES = 2 and 1.
module tb_sram_responder;

   logic clk;
   logic rst;

   sram_responder_if ifa ();
   sram_responder_if ifb ();

   logic [15:0] a_addr, b_addr;
   logic [7:0]  a_dq, b_dq, a_dq_in, b_dq_in;
   logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n;
   logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n;

   logic [7:0] mem_a [0:65535];
   logic [7:0] mem_b [0:65535];

   int compared;
   int mismatched;

   sram_responder #(.WAIT_CYCLES(2)) dut_a (
      .i_clk(clk), .i_reset(rst), .bus(ifa),
      .o_sram_addr(a_addr), .o_sram_dq(a_dq), .i_sram_dq(a_dq_in),
      .o_sram_dq_oe(a_dq_oe), .o_sram_ce_n(a_ce_n),
      .o_sram_oe_n(a_oe_n), .o_sram_we_n(a_we_n)
   );

   sram_responder #(.WAIT_CYCLES(1)) dut_b (
      .i_clk(clk), .i_reset(rst), .bus(ifb),
      .o_sram_addr(b_addr), .o_sram_dq(b_dq), .i_sram_dq(b_dq_in),
      .o_sram_dq_oe(b_dq_oe), .o_sram_ce_n(b_ce_n),
      .o_sram_oe_n(b_oe_n), .o_sram_we_n(b_we_n)
   );

   // Simple SRAM models: write while ce_n/we_n low with pads driven.
   assign a_dq_in = mem_a[a_addr];
   assign b_dq_in = mem_b[b_addr];

   always @(posedge clk) begin
      if (!a_ce_n && !a_we_n && a_dq_oe) mem_a[a_addr] <= a_dq;
      if (!b_ce_n && !b_we_n && b_dq_oe) mem_b[b_addr] <= b_dq;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // {ce_n, oe_n, we_n, dq_oe, ack}
   function automatic logic [4:0] va();
      return {a_ce_n, a_oe_n, a_we_n, a_dq_oe, ifa.o_ack};
   endfunction

   function automatic logic [4:0] vb();
      return {b_ce_n, b_oe_n, b_we_n, b_dq_oe, ifb.o_ack};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ifa.i_cs = 1'b0; ifa.i_we = 1'b0; ifa.i_addr = 16'h0; ifa.i_dat = 8'h0;
      ifb.i_cs = 1'b0; ifb.i_we = 1'b0; ifb.i_addr = 16'h0; ifb.i_dat = 8'h0;
      step();
      step();
      compared++;
      if (va() !== 5'b11100) begin
         mismatched++;
         $display("FAIL reset_pins_a: got %b expected %b", va(), 5'b11100);
      end
      compared++;
      if ({ifa.o_dat, a_addr, a_dq} !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_regs_a: got %h expected %h", {ifa.o_dat, a_addr, a_dq}, 32'h0);
      end
      compared++;
      if ({vb(), ifb.o_dat} !== {5'b11100, 8'h00}) begin
         mismatched++;
         $display("FAIL reset_b: got %h expected %h", {vb(), ifb.o_dat}, {5'b11100, 8'h00});
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_read();
      logic [4:0] exp_v [5];
      exp_v = '{5'b00100, 5'b00100, 5'b00100, 5'b01100, 5'b11101};
      ifa.i_addr = 16'h1234; ifa.i_we = 1'b0; ifa.i_cs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         compared++;
         if (va() !== exp_v[i]) begin
            mismatched++;
            $display("FAIL read_pins[%0d]: got %b expected %b", i, va(), exp_v[i]);
         end
         if (i == 2) begin
            compared++;
            if (ifa.o_dat !== 8'h00) begin
               mismatched++;
               $display("FAIL read_early_dat: got %h expected %h", ifa.o_dat, 8'h00);
            end
         end
         if (i >= 3) begin
            compared++;
            if (ifa.o_dat !== 8'h5A) begin
               mismatched++;
               $display("FAIL read_dat[%0d]: got %h expected %h", i, ifa.o_dat, 8'h5A);
            end
         end
      end
      ifa.i_cs = 1'b0;
      step();
   endtask

   task automatic test_write();
      logic [4:0] exp_v [5];
      exp_v = '{5'b01110, 5'b01010, 5'b01010, 5'b01110, 5'b11101};
      ifa.i_addr = 16'h1234; ifa.i_dat = 8'hA5; ifa.i_we = 1'b1; ifa.i_cs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 0) begin
            ifa.i_addr = 16'hFFFF; ifa.i_dat = 8'h00; ifa.i_we = 1'b0;
         end
         compared++;
         if (va() !== exp_v[i]) begin
            mismatched++;
            $display("FAIL write_pins[%0d]: got %b expected %b", i, va(), exp_v[i]);
         end
         compared++;
         if ({a_addr, a_dq} !== 24'h1234A5) begin
            mismatched++;
            $display("FAIL write_addr_dq[%0d]: got %h expected %h", i, {a_addr, a_dq}, 24'h1234A5);
         end
      end
      step();
      compared++;
      if (ifa.o_ack !== 1'b1) begin
         mismatched++;
         $display("FAIL write_ack_held: got %b expected 1", ifa.o_ack);
      end
      ifa.i_cs = 1'b0;
      #1;
      compared++;
      if (ifa.o_ack !== 1'b0) begin
         mismatched++;
         $display("FAIL write_ack_drop: got %b expected 0", ifa.o_ack);
      end
      step();
      compared++;
      if ({mem_a[16'h1234], ifa.o_dat} !== 16'hA55A) begin
         mismatched++;
         $display("FAIL write_mem: got %h expected %h", {mem_a[16'h1234], ifa.o_dat}, 16'hA55A);
      end
   endtask

   task automatic test_back_to_back();
      ifa.i_addr = 16'h0000; ifa.i_dat = 8'h01; ifa.i_we = 1'b1; ifa.i_cs = 1'b1;
      for (int i = 0; i < 5; i++) step();
      compared++;
      if (ifa.o_ack !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_write_ack: got %b expected 1", ifa.o_ack);
      end
      ifa.i_cs = 1'b0;
      step();
      compared++;
      if (va() !== 5'b11100) begin
         mismatched++;
         $display("FAIL b2b_gap: got %b expected %b", va(), 5'b11100);
      end
      ifa.i_we = 1'b0; ifa.i_cs = 1'b1;
      step();
      compared++;
      if ({va(), a_addr} !== {5'b00100, 16'h0000}) begin
         mismatched++;
         $display("FAIL b2b_read_start: got %h expected %h", {va(), a_addr}, {5'b00100, 16'h0000});
      end
      for (int i = 0; i < 3; i++) step();
      compared++;
      if (ifa.o_dat !== 8'h01) begin
         mismatched++;
         $display("FAIL b2b_read_dat: got %h expected %h", ifa.o_dat, 8'h01);
      end
      step();
      compared++;
      if (va() !== 5'b11101) begin
         mismatched++;
         $display("FAIL b2b_read_ack: got %b expected %b", va(), 5'b11101);
      end
      ifa.i_cs = 1'b0;
      step();
   endtask

   task automatic test_abort();
      int we_low;
      int ack_seen;
      we_low = 0;
      ack_seen = 0;
      ifa.i_addr = 16'h0042; ifa.i_dat = 8'h77; ifa.i_we = 1'b1; ifa.i_cs = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 1) ifa.i_cs = 1'b0;
         if (a_we_n == 1'b0) we_low++;
         if (ifa.o_ack == 1'b1) ack_seen++;
      end
      compared++;
      if (we_low !== 2) begin
         mismatched++;
         $display("FAIL abort_we_width: got %0d expected %0d", we_low, 2);
      end
      compared++;
      if (ack_seen !== 0) begin
         mismatched++;
         $display("FAIL abort_ack_seen: got %0d expected %0d", ack_seen, 0);
      end
      compared++;
      if ({va(), mem_a[16'h0042]} !== {5'b11100, 8'h77}) begin
         mismatched++;
         $display("FAIL abort_end: got %h expected %h", {va(), mem_a[16'h0042]}, {5'b11100, 8'h77});
      end
      ifa.i_we = 1'b0; ifa.i_cs = 1'b1;
      for (int i = 0; i < 5; i++) step();
      compared++;
      if ({va(), ifa.o_dat} !== {5'b11101, 8'h77}) begin
         mismatched++;
         $display("FAIL abort_reread: got %h expected %h", {va(), ifa.o_dat}, {5'b11101, 8'h77});
      end
      ifa.i_cs = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [4:0] exp_v [5];
      exp_v = '{5'b00100, 5'b00100, 5'b00100, 5'b01100, 5'b11101};
      ifa.i_addr = 16'h0100; ifa.i_dat = 8'h33; ifa.i_we = 1'b1; ifa.i_cs = 1'b1;
      step();
      step();
      compared++;
      if (va() !== 5'b01010) begin
         mismatched++;
         $display("FAIL rstmid_pre: got %b expected %b", va(), 5'b01010);
      end
      #2;
      rst = 1'b1;
      #1;
      compared++;
      if ({va(), ifa.o_dat} !== {5'b11100, 8'h00}) begin
         mismatched++;
         $display("FAIL rstmid_async: got %h expected %h", {va(), ifa.o_dat}, {5'b11100, 8'h00});
      end
      ifa.i_cs = 1'b0;
      step();
      rst = 1'b0;
      step();
      ifa.i_addr = 16'h0042; ifa.i_we = 1'b0; ifa.i_cs = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         compared++;
         if (va() !== exp_v[i]) begin
            mismatched++;
            $display("FAIL rstmid_read[%0d]: got %b expected %b", i, va(), exp_v[i]);
         end
      end
      compared++;
      if (ifa.o_dat !== 8'h77) begin
         mismatched++;
         $display("FAIL rstmid_dat: got %h expected %h", ifa.o_dat, 8'h77);
      end
      ifa.i_cs = 1'b0;
      step();
   endtask

   task automatic test_w1();
      logic [4:0] exp_w [4];
      logic [4:0] exp_r [4];
      exp_w = '{5'b01110, 5'b01010, 5'b01110, 5'b11101};
      exp_r = '{5'b00100, 5'b00100, 5'b01100, 5'b11101};
      ifb.i_addr = 16'h0005; ifb.i_dat = 8'hC3; ifb.i_we = 1'b1; ifb.i_cs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         compared++;
         if (vb() !== exp_w[i]) begin
            mismatched++;
            $display("FAIL w1_write[%0d]: got %b expected %b", i, vb(), exp_w[i]);
         end
      end
      ifb.i_cs = 1'b0;
      step();
      ifb.i_we = 1'b0; ifb.i_cs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         compared++;
         if (vb() !== exp_r[i]) begin
            mismatched++;
            $display("FAIL w1_read[%0d]: got %b expected %b", i, vb(), exp_r[i]);
         end
         if (i == 2) begin
            compared++;
            if (ifb.o_dat !== 8'hC3) begin
               mismatched++;
               $display("FAIL w1_read_dat: got %h expected %h", ifb.o_dat, 8'hC3);
            end
         end
      end
      ifb.i_cs = 1'b0;
      step();
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      mem_a[16'h1234] = 8'h5A;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_w1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
